// File: rtl/status_array_writer.sv
// Purpose: write-side controller for the I-cache status (valid-bit) array; post-reset zero sweep,
//          then fill / inval-block / inval-row / flush requests turned into masked row writes.
// Latency: an accepted request appears on o_sa_* at the accepting edge; flush sweeps one row per cycle.
// Backpressure: o_sa_* holds while i_sa_ready is low; o_req_ready drops, so requests stall upstream.
//
// Ports:
//   clk, srst                 clock, synchronous active-high reset
//   i_req_valid/op/addr/blk   request from cache controller (op 00 fill, 01 inval blk, 10 inval row, 11 flush)
//   o_req_ready               request accepted when i_req_valid & o_req_ready
//   i_sa_ready                status array can take a write this cycle
//   o_sa_valid/wen/addr/data/wmask  registered write command to the status array
//   o_init_done               sticky once the post-reset sweep finished
//   o_busy                    sweeping, or a command still pending
module status_array_writer #(
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_BLOCKS = 8,
  parameter int BLK_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  i_req_valid,
  input  logic [1:0]            i_req_op,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [BLK_WIDTH-1:0]  i_req_blk,
  output logic                  o_req_ready,
  input  logic                  i_sa_ready,
  output logic                  o_sa_valid,
  output logic                  o_sa_wen,
  output logic [ADDR_WIDTH-1:0] o_sa_addr,
  output logic [NUM_BLOCKS-1:0] o_sa_data,
  output logic [NUM_BLOCKS-1:0] o_sa_wmask,
  output logic                  o_init_done,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] OP_FILL      = 2'b00;
  localparam logic [1:0] OP_INVAL_BLK = 2'b01;
  localparam logic [1:0] OP_INVAL_ROW = 2'b10;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    sa_valid_q, sa_valid_d;
  logic [ADDR_WIDTH-1:0]   sa_addr_q, sa_addr_d;
  logic [NUM_BLOCKS-1:0]   sa_data_q, sa_data_d;
  logic [NUM_BLOCKS-1:0]   sa_wmask_q, sa_wmask_d;
  logic                    init_done_q, init_done_d;

  logic                    adv;
  logic [NUM_BLOCKS-1:0]   blk_onehot;

  // The output register may load whenever it is empty or being drained this edge.
  assign adv = ~sa_valid_q | i_sa_ready;

  // Out-of-range block indices give an all-zero mask, making the write a no-op.
  always_comb begin
    blk_onehot = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      blk_onehot[i] = (int'(i_req_blk) == i);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sa_valid_d  = sa_valid_q;
    sa_addr_d   = sa_addr_q;
    sa_data_d   = sa_data_q;
    sa_wmask_d  = sa_wmask_q;
    init_done_d = init_done_q;

    if (adv) begin
      case (state_q)
        ST_INIT, ST_FLUSH: begin
          sa_valid_d = 1'b1;
          sa_addr_d  = cnt_q;
          sa_data_d  = '0;
          sa_wmask_d = '1;
          if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (state_q == ST_INIT) init_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          // Idle: the previous command has drained; addr/data/mask keep their last values.
          sa_valid_d = 1'b0;
          if (i_req_valid) begin
            case (i_req_op)
              OP_FILL: begin
                sa_valid_d = 1'b1;
                sa_addr_d  = i_req_addr;
                sa_data_d  = '1;
                sa_wmask_d = blk_onehot;
              end
              OP_INVAL_BLK: begin
                sa_valid_d = 1'b1;
                sa_addr_d  = i_req_addr;
                sa_data_d  = '0;
                sa_wmask_d = blk_onehot;
              end
              OP_INVAL_ROW: begin
                sa_valid_d = 1'b1;
                sa_addr_d  = i_req_addr;
                sa_data_d  = '0;
                sa_wmask_d = '1;
              end
              default: begin
                // Flush: no write on the accept edge; the sweep begins next edge from row 0.
                state_d = ST_FLUSH;
                cnt_d   = '0;
              end
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      sa_valid_q  <= 1'b0;
      sa_addr_q   <= '0;
      sa_data_q   <= '0;
      sa_wmask_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sa_valid_q  <= sa_valid_d;
      sa_addr_q   <= sa_addr_d;
      sa_data_q   <= sa_data_d;
      sa_wmask_q  <= sa_wmask_d;
      init_done_q <= init_done_d;
    end
  end

  assign o_req_ready = (state_q == ST_IDLE) & adv;
  assign o_sa_valid  = sa_valid_q;
  assign o_sa_wen    = sa_valid_q;
  assign o_sa_addr   = sa_addr_q;
  assign o_sa_data   = sa_data_q;
  assign o_sa_wmask  = sa_wmask_q;
  assign o_init_done = init_done_q;
  assign o_busy      = (state_q != ST_IDLE) | sa_valid_q;

endmodule

// File: tb/tb_status_array_writer.sv
module tb_status_array_writer;

  localparam int AW = 4;
  localparam int NB = 8;
  localparam int BW = 4;  // one spare bit so an out-of-range block index can be driven

  logic          clk = 1'b0;
  logic          srst;
  logic          i_req_valid;
  logic [1:0]    i_req_op;
  logic [AW-1:0] i_req_addr;
  logic [BW-1:0] i_req_blk;
  logic          o_req_ready;
  logic          i_sa_ready;
  logic          o_sa_valid;
  logic          o_sa_wen;
  logic [AW-1:0] o_sa_addr;
  logic [NB-1:0] o_sa_data;
  logic [NB-1:0] o_sa_wmask;
  logic          o_init_done;
  logic          o_busy;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int snap;

  status_array_writer #(.ADDR_WIDTH(AW), .NUM_BLOCKS(NB), .BLK_WIDTH(BW)) dut (
    .clk(clk), .srst(srst),
    .i_req_valid(i_req_valid), .i_req_op(i_req_op), .i_req_addr(i_req_addr), .i_req_blk(i_req_blk),
    .o_req_ready(o_req_ready), .i_sa_ready(i_sa_ready),
    .o_sa_valid(o_sa_valid), .o_sa_wen(o_sa_wen), .o_sa_addr(o_sa_addr),
    .o_sa_data(o_sa_data), .o_sa_wmask(o_sa_wmask),
    .o_init_done(o_init_done), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Counts writes actually handed to the array.
  always @(posedge clk) begin
    if (!srst && o_sa_valid && i_sa_ready) wr_cnt <= wr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cmd(input string tag, input logic [AW-1:0] a, input logic [NB-1:0] d,
                         input logic [NB-1:0] m);
    chk({tag, ".valid"}, 32'(o_sa_valid), 32'd1);
    chk({tag, ".wen"},   32'(o_sa_wen),   32'd1);
    chk({tag, ".addr"},  32'(o_sa_addr),  32'(a));
    chk({tag, ".data"},  32'(o_sa_data),  32'(d));
    chk({tag, ".wmask"}, 32'(o_sa_wmask), 32'(m));
  endtask

  task automatic req(input logic [1:0] op, input logic [AW-1:0] a, input logic [BW-1:0] b);
    i_req_valid = 1'b1;
    i_req_op    = op;
    i_req_addr  = a;
    i_req_blk   = b;
  endtask

  initial begin
    srst = 1'b1; i_req_valid = 1'b0; i_req_op = 2'b00; i_req_addr = '0; i_req_blk = '0;
    i_sa_ready = 1'b1;
    step(); step();

    // Reset state
    chk("rst.valid", 32'(o_sa_valid), 32'd0);
    chk("rst.wen", 32'(o_sa_wen), 32'd0);
    chk("rst.addr", 32'(o_sa_addr), 32'd0);
    chk("rst.wmask", 32'(o_sa_wmask), 32'd0);
    chk("rst.init_done", 32'(o_init_done), 32'd0);
    chk("rst.ready", 32'(o_req_ready), 32'd0);
    chk("rst.busy", 32'(o_busy), 32'd1);

    // 1. Init sweep: rows 0..15, init_done at cycle 16
    srst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk_cmd("init", AW'(k - 1), 8'h00, 8'hFF);
      chk("init.done", 32'(o_init_done), (k == 16) ? 32'd1 : 32'd0);
      chk("init.ready", 32'(o_req_ready), (k == 16) ? 32'd1 : 32'd0);
    end
    step();
    chk("idle.valid", 32'(o_sa_valid), 32'd0);
    chk("idle.busy", 32'(o_busy), 32'd0);
    chk("idle.ready", 32'(o_req_ready), 32'd1);
    chk("idle.addr_hold", 32'(o_sa_addr), 32'd15);

    // 2. Fill then inval block
    req(2'b00, 4'd5, 4'd3);
    step();
    chk_cmd("fill53", 4'd5, 8'hFF, 8'h08);
    req(2'b01, 4'd5, 4'd3);
    step();
    chk_cmd("inv53", 4'd5, 8'h00, 8'h08);
    i_req_valid = 1'b0;
    step();
    chk("after_inv.valid", 32'(o_sa_valid), 32'd0);
    chk("after_inv.wen", 32'(o_sa_wen), 32'd0);

    // Out-of-range block: issued with an empty mask
    req(2'b00, 4'd6, 4'd8);
    step();
    chk_cmd("fill_oob", 4'd6, 8'hFF, 8'h00);
    i_req_valid = 1'b0;
    step();

    // 3. Stall with a command pending
    i_sa_ready = 1'b0;
    req(2'b00, 4'd9, 4'd0);
    step();
    chk_cmd("stall_load", 4'd9, 8'hFF, 8'h01);
    req(2'b10, 4'd2, 4'd0);  // must be ignored while stalled
    snap = wr_cnt;
    for (int k = 0; k < 4; k++) begin
      chk("stall.ready", 32'(o_req_ready), 32'd0);
      step();
      chk_cmd("stall_hold", 4'd9, 8'hFF, 8'h01);
    end
    chk("stall.no_write", 32'(wr_cnt - snap), 32'd0);
    i_sa_ready = 1'b1;
    i_req_valid = 1'b0;
    step();
    chk("recover.valid", 32'(o_sa_valid), 32'd0);
    chk("recover.once", 32'(wr_cnt - snap), 32'd1);

    // 4. Flush
    req(2'b11, 4'd0, 4'd0);
    step();
    i_req_valid = 1'b0;
    chk("flush_acc.valid", 32'(o_sa_valid), 32'd0);
    chk("flush_acc.busy", 32'(o_busy), 32'd1);
    chk("flush_acc.ready", 32'(o_req_ready), 32'd0);
    for (int k = 0; k < 16; k++) begin
      step();
      chk_cmd("flush", AW'(k), 8'h00, 8'hFF);
      chk("flush.done", 32'(o_init_done), 32'd1);
      chk("flush.busy", 32'(o_busy), 32'd1);
      chk("flush.ready", 32'(o_req_ready), (k == 15) ? 32'd1 : 32'd0);
    end
    step();
    chk("flush_end.valid", 32'(o_sa_valid), 32'd0);
    chk("flush_end.busy", 32'(o_busy), 32'd0);
    chk("flush_end.done", 32'(o_init_done), 32'd1);

    // 6. Back-to-back requests
    req(2'b00, 4'd1, 4'd0);
    step();
    chk_cmd("b2b0", 4'd1, 8'hFF, 8'h01);
    chk("b2b0.ready", 32'(o_req_ready), 32'd1);
    req(2'b00, 4'd2, 4'd7);
    step();
    chk_cmd("b2b1", 4'd2, 8'hFF, 8'h80);
    req(2'b10, 4'd3, 4'd0);
    step();
    chk_cmd("b2b2", 4'd3, 8'h00, 8'hFF);
    i_req_valid = 1'b0;
    step();
    chk("b2b_end.valid", 32'(o_sa_valid), 32'd0);

    // 5. Reset mid-sweep at row 7
    srst = 1'b1;
    step();
    srst = 1'b0;
    for (int k = 0; k < 8; k++) step();
    chk_cmd("pre_rst", 4'd7, 8'h00, 8'hFF);
    srst = 1'b1;
    step();
    chk("midrst.valid", 32'(o_sa_valid), 32'd0);
    chk("midrst.addr", 32'(o_sa_addr), 32'd0);
    chk("midrst.wmask", 32'(o_sa_wmask), 32'd0);
    chk("midrst.done", 32'(o_init_done), 32'd0);
    srst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk_cmd("resweep", AW'(k - 1), 8'h00, 8'hFF);
      chk("resweep.done", 32'(o_init_done), (k == 16) ? 32'd1 : 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound on runtime.
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: got no completion expected finish before 100000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
